// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selectors and legal prescale ratios.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample position counter: edge_cnt runs 0..Prescale-1 per bit and bumps bit_cnt on wrap.
module uart_rx_edge_bit_cnt #(
    parameter int PRESC_W = 6,
    parameter int CNT_W   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] prescale_i,
    output logic [PRESC_W-1:0] edge_cnt_o,
    output logic [CNT_W-1:0]   bit_cnt_o,
    output logic               bit_end_o
);

    logic [PRESC_W-1:0] edge_q;
    logic [CNT_W-1:0]   bit_q;
    logic               at_wrap;

    assign at_wrap = (edge_q == (prescale_i - PRESC_W'(1)));

    // Disabled means IDLE: both counters sit at zero so a new frame starts cleanly.
    always_ff @(posedge CLK) begin
        if (RST || !en_i) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (at_wrap) begin
            edge_q <= '0;
            bit_q  <= bit_q + CNT_W'(1);
        end else begin
            edge_q <= edge_q + PRESC_W'(1);
        end
    end

    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;
    assign bit_end_o  = en_i && at_wrap;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver (start, DATA_WIDTH bits LSB first, optional parity, stop).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around the bit centre.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 4);

    rx_state_e             state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_err_q;
    logic                  sample_q;
    logic                  dv_q;
    logic                  pe_q;
    logic                  se_q;

    logic [PRESC_W-1:0]    edge_cnt;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  bit_end;
    logic                  cnt_en;
    logic [PRESC_W-1:0]    pt_mid;
    logic [PRESC_W-1:0]    pt_latch;
    logic                  bit_val;

    assign cnt_en   = (state_q != ST_IDLE);
    assign pt_mid   = Prescale >> 1;
    assign pt_latch = pt_mid + PRESC_W'(1);

    uart_rx_edge_bit_cnt #(
        .PRESC_W (PRESC_W),
        .CNT_W   (CNT_W)
    ) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .en_i       (cnt_en),
        .prescale_i (Prescale),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt),
        .bit_end_o  (bit_end)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0]         smp_q;
    logic [PRESC_W-1:0] pt_early;

    assign pt_early = pt_mid - PRESC_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            smp_q <= '0;
        end else begin
            if (edge_cnt == pt_early) smp_q[0] <= RX_IN;
            if (edge_cnt == pt_mid)   smp_q[1] <= RX_IN;
        end
    end

    // Third vote is the live line value on the latch cycle.
    assign bit_val = maj3(smp_q[0], smp_q[1], RX_IN);
`else
    logic smp_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            smp_q <= 1'b1;
        end else if (edge_cnt == pt_mid) begin
            smp_q <= RX_IN;
        end
    end

    assign bit_val = smp_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            sample_q <= 1'b1;
        end else if (cnt_en && (edge_cnt == pt_latch)) begin
            sample_q <= bit_val;
        end
    end

    // state  | meaning
    // IDLE   | line idle, waiting for a low level
    // START  | start bit; a high sample means glitch, back to IDLE
    // DATA   | shift DATA_WIDTH samples in LSB first
    // PARITY | compare sample against expected parity
    // STOP   | stop bit; outcome pulse registered on exit
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            p_data_q  <= '0;
            par_err_q <= 1'b0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!RX_IN) begin
                        state_q   <= ST_START;
                        par_err_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q <= sample_q ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        data_q <= {sample_q, data_q[DATA_WIDTH-1:1]};
                        if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
                            state_q <= PAR_EN ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        par_err_q <= sample_q ^ (^data_q) ^ PAR_TYP;
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        state_q <= ST_IDLE;
                        if (!sample_q) begin
                            se_q <= 1'b1;
                        end else if (par_err_q) begin
                            pe_q <= 1'b1;
                        end else begin
                            dv_q     <= 1'b1;
                            p_data_q <= data_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign P_DATA       = p_data_q;
    assign Data_Valid   = dv_q;
    assign parity_error = pe_q;
    assign stop_error   = se_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed cases plus random frames against a line-level decode model.
module tb_uart_rx_core;

    localparam int W = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       parity_error;
    logic       stop_error;

    uart_rx_core #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .Prescale     (Prescale),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // kind: 1 = Data_Valid, 2 = parity_error, 3 = stop_error, 4 = several at once
    typedef struct {
        int         kind;
        int         t;
        logic [7:0] d;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    ev_t mon_e;
    int  mon_n;

    always begin
        @(posedge CLK);
        #1;
        mon_n = int'(Data_Valid) + int'(parity_error) + int'(stop_error);
        if (mon_n != 0) begin
            mon_e.kind = (mon_n > 1) ? 4 : (Data_Valid ? 1 : (parity_error ? 2 : 3));
            mon_e.t    = cyc;
            mon_e.d    = P_DATA;
            obs_q.push_back(mon_e);
        end
    end

    int         ncmp = 0;
    int         nfail = 0;
    bit         wave_q[$];
    logic [7:0] exp_pdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line value seen by the receiver i cycles after it first detected the start edge.
    function automatic bit line_at(input int i);
        return (i < wave_q.size()) ? wave_q[i] : 1'b1;
    endfunction

    // The bit centre of frame bit b lands P/2+1 cycles into its window (one cycle of detection lag).
    function automatic bit samp(input int b, input int p);
        int idx;
        idx = b * p + p / 2 + 1;
`ifdef UART_RX_MAJORITY_EN
        return (int'(line_at(idx - 1)) + int'(line_at(idx)) + int'(line_at(idx + 1))) >= 2;
`else
        return line_at(idx);
`endif
    endfunction

    task automatic model(input int p, input bit pe, input bit pt, output int kind, output logic [7:0] d);
        bit want;
        d    = 8'h00;
        kind = 0;
        if (samp(0, p)) return;
        for (int i = 0; i < W; i++) d[i] = samp(1 + i, p);
        want = (($countones(d) % 2) == 1) ^ pt;
        if (!samp(W + 1 + int'(pe), p))          kind = 3;
        else if (pe && (samp(W + 1, p) != want)) kind = 2;
        else                                     kind = 1;
    endtask

    task automatic push_bit(input bit v, input int p);
        for (int k = 0; k < p; k++) wave_q.push_back(v);
    endtask

    task automatic build(input logic [7:0] d, input bit pe, input bit pt, input bit bad_par,
                         input bit stop_v, input int p);
        wave_q.delete();
        push_bit(1'b0, p);
        for (int i = 0; i < W; i++) push_bit(d[i], p);
        if (pe) push_bit(((($countones(d) % 2) == 1) ^ pt) ^ bad_par, p);
        push_bit(stop_v, p);
    endtask

    task automatic send(input int p, input bit pe, input bit pt, input int gap);
        int         kind;
        int         t0;
        logic [7:0] d;
        ev_t        e;
        t0 = 0;
        model(p, pe, pt, kind, d);
        for (int i = 0; i < wave_q.size(); i++) begin
            @(negedge CLK);
            if (i == 0) begin
                Prescale = 6'(p);
                PAR_EN   = pe;
                PAR_TYP  = pt;
                t0       = cyc + 1;
            end
            RX_IN = wave_q[i];
        end
        repeat (gap) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
        if (kind != 0) begin
            e.kind = kind;
            e.t    = t0 + (W + 2 + int'(pe)) * p;
            e.d    = (kind == 1) ? d : exp_pdata;
            if (kind == 1) exp_pdata = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_events(input string tag);
        ev_t o;
        ev_t x;
        repeat (3) @(negedge CLK);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            chk({tag, "_kind"}, o.kind, x.kind);
            chk({tag, "_time"}, o.t, x.t);
            chk({tag, "_data"}, o.d, x.d);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int         p;
        bit         pe;
        bit         pt;
        int         err;
        logic [7:0] d;
        int         presc_tab [3] = '{8, 16, 32};

        RST      = 1'b1;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd8;
        repeat (3) @(negedge CLK);
        chk("rst_pdata", P_DATA, 8'h00);
        chk("rst_dv", Data_Valid, 1'b0);
        chk("rst_pe", parity_error, 1'b0);
        chk("rst_se", stop_error, 1'b0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Plain frame, latency 8*10 from the start edge.
        build(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8);
        send(8, 1'b0, 1'b0, 2);
        check_events("t1_a5");
        chk("t1_pdata", P_DATA, 8'hA5);

        // Even parity good, then bad parity bit.
        build(8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 16);
        send(16, 1'b1, 1'b0, 2);
        check_events("t2_good");
        chk("t2_pdata", P_DATA, 8'h37);
        build(8'h37, 1'b1, 1'b0, 1'b1, 1'b1, 16);
        send(16, 1'b1, 1'b0, 2);
        check_events("t2_bad");
        chk("t2_pdata_held", P_DATA, 8'h37);

        // Stop bit sampled low.
        build(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 32);
        send(32, 1'b0, 1'b0, 2);
        check_events("t3_stop");
        chk("t3_pdata_held", P_DATA, 8'h37);

        // Short low glitch; the next start arrives right after the start-bit window.
        wave_q.delete();
        repeat (3) wave_q.push_back(1'b0);
        send(16, 1'b0, 1'b0, 14);
        build(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        send(16, 1'b0, 1'b0, 2);
        check_events("t4_glitch");

        // One-cycle inversion on the centre of data bit 3.
        build(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        wave_q[4 * 16 + 16 / 2 + 1] = 1'b1;
        send(16, 1'b0, 1'b0, 2);
        check_events("t5_flip");
`ifdef UART_RX_MAJORITY_EN
        chk("t5_pdata", P_DATA, 8'h00);
`else
        chk("t5_pdata", P_DATA, 8'h08);
`endif

        // Break: line low through a whole frame, then a one-cycle restart glitch.
        wave_q.delete();
        repeat (10 * 16 + 2) wave_q.push_back(1'b0);
        send(16, 1'b0, 1'b0, 30);
        check_events("t_break");

        // Back-to-back: second start is detected in the pulse cycle of the first.
        build(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        send(16, 1'b0, 1'b0, 1);
        build(8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        send(16, 1'b0, 1'b0, 2);
        check_events("t6_b2b");
        chk("t6_pdata", P_DATA, 8'hEE);

        // Reset in the middle of a third frame.
        build(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        for (int i = 0; i < 70; i++) begin
            @(negedge CLK);
            RX_IN = wave_q[i];
        end
        @(negedge CLK);
        RST   = 1'b1;
        RX_IN = 1'b1;
        @(posedge CLK);
        #1;
        chk("t6_rst_pdata", P_DATA, 8'h00);
        chk("t6_rst_dv", Data_Valid, 1'b0);
        chk("t6_rst_pe", parity_error, 1'b0);
        chk("t6_rst_se", stop_error, 1'b0);
        @(negedge CLK);
        RST       = 1'b0;
        exp_pdata = 8'h00;
        repeat (200) @(negedge CLK);
        check_events("t6_after_rst");

        // Random frames with injected parity/stop faults and single-cycle glitches.
        for (int n = 0; n < 24; n++) begin
            p   = presc_tab[$urandom_range(0, 2)];
            pe  = 1'($urandom_range(0, 1));
            pt  = 1'($urandom_range(0, 1));
            d   = 8'($urandom_range(0, 255));
            err = $urandom_range(0, 5);
            build(d, pe, pt, (err == 0), (err != 1), p);
            if ($urandom_range(0, 2) == 0)
                wave_q[p + $urandom_range(0, (W + int'(pe)) * p - 1)] ^= 1'b1;
            send(p, pe, pt, $urandom_range(1, 4));
            check_events("rand");
            chk("rand_pdata", P_DATA, exp_pdata);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
